// File: rtl/cpu64_l2_dir_pkg.sv
// Shared definitions for the L2 coherence directory: opcodes, FSM states and
// the packing layout of one directory entry as a function of core count.
package cpu64_l2_dir_pkg;

    localparam logic [2:0] DIR_OP_WRITE      = 3'd0;
    localparam logic [2:0] DIR_OP_ADD_SHARER = 3'd1;
    localparam logic [2:0] DIR_OP_DEL_SHARER = 3'd2;
    localparam logic [2:0] DIR_OP_SET_OWNER  = 3'd3;
    localparam logic [2:0] DIR_OP_CLR_OWNER  = 3'd4;
    localparam logic [2:0] DIR_OP_INVALIDATE = 3'd5;

    typedef enum logic {
        DIR_ST_INIT,
        DIR_ST_RUN
    } dir_state_e;

    // Entry layout, LSB first: valid | sharers[CORES] | owner_valid | owner_id[CW] | dirty
    localparam int DIR_OFF_VALID   = 0;
    localparam int DIR_OFF_SHARERS = 1;

    function automatic int dir_off_owner_valid(input int cores);
        return 1 + cores;
    endfunction

    function automatic int dir_off_owner_id(input int cores);
        return 2 + cores;
    endfunction

    function automatic int dir_off_dirty(input int cores, input int cw);
        return 2 + cores + cw;
    endfunction

    function automatic int dir_entry_w(input int cores, input int cw);
        return 3 + cores + cw;
    endfunction

endpackage

// File: rtl/cpu64_l2_dir_entry_update.sv
// Combinational read-modify-write of one directory entry: applies the opcode,
// then the coherence invariants; a rejected op returns the old entry untouched.
module cpu64_l2_dir_entry_update
    import cpu64_l2_dir_pkg::*;
#(
    parameter  int CORES = 4,
    localparam int CW    = $clog2(CORES),
    localparam int EW    = dir_entry_w(CORES, CW)
) (
    input  logic [EW-1:0]    old_i,
    input  logic [2:0]       op_i,
    input  logic [CW-1:0]    core_i,
    input  logic [CORES-1:0] sharers_i,
    input  logic             owner_valid_i,
    input  logic             dirty_i,
    output logic [EW-1:0]    new_o,
    output logic             err_o
);

    localparam int OFF_OV  = dir_off_owner_valid(CORES);
    localparam int OFF_OID = dir_off_owner_id(CORES);
    localparam int OFF_D   = dir_off_dirty(CORES, CW);

    logic             old_valid, old_ov, old_dirty;
    logic [CORES-1:0] old_sharers;
    logic [CW-1:0]    old_oid;

    logic             valid, owner_valid, dirty;
    logic [CORES-1:0] sharers;
    logic [CW-1:0]    owner_id;

    assign old_valid   = old_i[DIR_OFF_VALID];
    assign old_sharers = old_i[DIR_OFF_SHARERS +: CORES];
    assign old_ov      = old_i[OFF_OV];
    assign old_oid     = old_i[OFF_OID +: CW];
    assign old_dirty   = old_i[OFF_D];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        valid       = old_valid;
        sharers     = old_sharers;
        owner_valid = old_ov;
        owner_id    = old_oid;
        dirty       = old_dirty;
        err_o       = 1'b0;

        case (op_i)
            DIR_OP_WRITE: begin
                valid       = 1'b1;
                sharers     = sharers_i;
                owner_valid = owner_valid_i;
                owner_id    = core_i;
                dirty       = dirty_i;
            end
            DIR_OP_ADD_SHARER: begin
                if (old_ov) begin
                    err_o = 1'b1;
                end else begin
                    valid           = 1'b1;
                    sharers[core_i] = 1'b1;
                end
            end
            DIR_OP_DEL_SHARER: begin
                if (!old_valid) begin
                    err_o = 1'b1;
                end else begin
                    sharers[core_i] = 1'b0;
                    if (old_ov && (old_oid == core_i)) begin
                        owner_valid = 1'b0;
                        dirty       = 1'b0;
                    end
                end
            end
            DIR_OP_SET_OWNER: begin
                valid       = 1'b1;
                owner_id    = core_i;
                owner_valid = 1'b1;
                dirty       = dirty_i;
            end
            DIR_OP_CLR_OWNER: begin
                if (!old_ov) begin
                    err_o = 1'b1;
                end else begin
                    owner_valid = 1'b0;
                    dirty       = 1'b0;
                    sharers     = CORES'(1) << old_oid;
                end
            end
            DIR_OP_INVALIDATE: begin
                valid       = 1'b0;
                sharers     = '0;
                owner_valid = 1'b0;
                owner_id    = '0;
                dirty       = 1'b0;
            end
            default: err_o = 1'b1;
        endcase

        // Invariants, in priority order; the owner id is canonicalised to 0 when unowned.
        if (dirty)        owner_valid = 1'b1;
        if (owner_valid)  sharers     = '0;
        if (!owner_valid) owner_id    = '0;
        if (!valid) begin
            sharers     = '0;
            owner_valid = 1'b0;
            owner_id    = '0;
            dirty       = 1'b0;
        end
    end

    assign new_o = err_o ? old_i : {dirty, owner_id, owner_valid, sharers, valid};

endmodule

// File: rtl/cpu64_l2_directory_rmw.sv
// L2 coherence directory: post-reset init sweep, single-cycle atomic update
// port and a registered lookup port that forwards same-cycle updates.
module cpu64_l2_directory_rmw
    import cpu64_l2_dir_pkg::*;
#(
    parameter  int SETS  = 256,
    parameter  int WAYS  = 16,
    parameter  int CORES = 4,
    localparam int SW    = $clog2(SETS),
    localparam int WW    = $clog2(WAYS),
    localparam int CW    = $clog2(CORES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done_o,
    input  logic                  lk_valid_i,
    output logic                  lk_ready_o,
    input  logic [SW-1:0]         lk_set_i,
    output logic                  rsp_valid_o,
    output logic [WAYS-1:0]       rsp_valid_ways_o,
    output logic [WAYS*CORES-1:0] rsp_sharers_o,
    output logic [WAYS-1:0]       rsp_owner_valid_o,
    output logic [WAYS*CW-1:0]    rsp_owner_id_o,
    output logic [WAYS-1:0]       rsp_dirty_o,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [SW-1:0]         up_set_i,
    input  logic [WW-1:0]         up_way_i,
    input  logic [2:0]            up_op_i,
    input  logic [CW-1:0]         up_core_i,
    input  logic [CORES-1:0]      up_sharers_i,
    input  logic                  up_owner_valid_i,
    input  logic                  up_dirty_i,
    output logic                  up_err_o
);

    localparam int EW      = dir_entry_w(CORES, CW);
    localparam int OFF_OV  = dir_off_owner_valid(CORES);
    localparam int OFF_OID = dir_off_owner_id(CORES);
    localparam int OFF_D   = dir_off_dirty(CORES, CW);

    dir_state_e    state_q, state_d;
    logic [SW-1:0] init_set_q, init_set_d;
    logic          init_clear;

    logic [EW-1:0] mem_q [SETS][WAYS];
    logic [EW-1:0] upd_old, upd_new;
    logic [EW-1:0] lk_ways [WAYS];
    logic          up_fire, lk_fire, upd_err, up_we;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [WAYS-1:0]       rsp_valid_ways_q, rsp_valid_ways_d;
    logic [WAYS*CORES-1:0] rsp_sharers_q, rsp_sharers_d;
    logic [WAYS-1:0]       rsp_owner_valid_q, rsp_owner_valid_d;
    logic [WAYS*CW-1:0]    rsp_owner_id_q, rsp_owner_id_d;
    logic [WAYS-1:0]       rsp_dirty_q, rsp_dirty_d;
    logic                  up_err_q, up_err_d;

    assign init_done_o = (state_q == DIR_ST_RUN);
    assign lk_ready_o  = init_done_o;
    assign up_ready_o  = init_done_o;
    assign up_fire     = up_valid_i && up_ready_o;
    assign lk_fire     = lk_valid_i && lk_ready_o;

    always_comb begin
        state_d    = state_q;
        init_set_d = init_set_q;
        init_clear = 1'b0;
        case (state_q)
            DIR_ST_INIT: begin
                init_clear = 1'b1;
                if (init_set_q == SW'(SETS - 1)) begin
                    state_d = DIR_ST_RUN;
                end else begin
                    init_set_d = init_set_q + SW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIR_ST_INIT;
            init_set_q <= '0;
        end else begin
            state_q    <= state_d;
            init_set_q <= init_set_d;
        end
    end

    assign upd_old = mem_q[up_set_i][up_way_i];

    cpu64_l2_dir_entry_update #(
        .CORES(CORES)
    ) u_entry_update (
        .old_i        (upd_old),
        .op_i         (up_op_i),
        .core_i       (up_core_i),
        .sharers_i    (up_sharers_i),
        .owner_valid_i(up_owner_valid_i),
        .dirty_i      (up_dirty_i),
        .new_o        (upd_new),
        .err_o        (upd_err)
    );

    assign up_we = up_fire && !upd_err;

    // NOTE: the array has no reset branch; the init sweep clears it, which keeps it mappable to RAM-like storage.
    always_ff @(posedge clk) begin
        if (init_clear) begin
            for (int w = 0; w < WAYS; w++) begin
                mem_q[init_set_q][w] <= '0;
            end
        end else if (up_we) begin
            mem_q[up_set_i][up_way_i] <= upd_new;
        end
    end

    // Lookup sees the post-update value of a way written in the same cycle.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            lk_ways[w] = mem_q[lk_set_i][w];
        end
        if (up_we && (up_set_i == lk_set_i)) begin
            lk_ways[up_way_i] = upd_new;
        end
    end

    always_comb begin
        rsp_valid_d       = lk_fire;
        rsp_valid_ways_d  = rsp_valid_ways_q;
        rsp_sharers_d     = rsp_sharers_q;
        rsp_owner_valid_d = rsp_owner_valid_q;
        rsp_owner_id_d    = rsp_owner_id_q;
        rsp_dirty_d       = rsp_dirty_q;
        up_err_d          = up_fire && upd_err;
        if (lk_fire) begin
            for (int w = 0; w < WAYS; w++) begin
                rsp_valid_ways_d[w]              = lk_ways[w][DIR_OFF_VALID];
                rsp_sharers_d[w*CORES +: CORES]  = lk_ways[w][DIR_OFF_SHARERS +: CORES];
                rsp_owner_valid_d[w]             = lk_ways[w][OFF_OV];
                rsp_owner_id_d[w*CW +: CW]       = lk_ways[w][OFF_OID +: CW];
                rsp_dirty_d[w]                   = lk_ways[w][OFF_D];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q       <= 1'b0;
            rsp_valid_ways_q  <= '0;
            rsp_sharers_q     <= '0;
            rsp_owner_valid_q <= '0;
            rsp_owner_id_q    <= '0;
            rsp_dirty_q       <= '0;
            up_err_q          <= 1'b0;
        end else begin
            rsp_valid_q       <= rsp_valid_d;
            rsp_valid_ways_q  <= rsp_valid_ways_d;
            rsp_sharers_q     <= rsp_sharers_d;
            rsp_owner_valid_q <= rsp_owner_valid_d;
            rsp_owner_id_q    <= rsp_owner_id_d;
            rsp_dirty_q       <= rsp_dirty_d;
            up_err_q          <= up_err_d;
        end
    end

    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_valid_ways_o  = rsp_valid_ways_q;
    assign rsp_sharers_o     = rsp_sharers_q;
    assign rsp_owner_valid_o = rsp_owner_valid_q;
    assign rsp_owner_id_o    = rsp_owner_id_q;
    assign rsp_dirty_o       = rsp_dirty_q;
    assign up_err_o          = up_err_q;

endmodule

// File: tb/tb_cpu64_l2_directory_rmw.sv
// Self-checking bench for cpu64_l2_directory_rmw: a behavioural directory model
// feeds a response scoreboard, plus directed checks of the documented scenarios.
module tb_cpu64_l2_directory_rmw;

    localparam int SETS  = 256;
    localparam int WAYS  = 16;
    localparam int CORES = 4;
    localparam int SW    = $clog2(SETS);
    localparam int WW    = $clog2(WAYS);
    localparam int CW    = $clog2(CORES);

    localparam int OP_WRITE = 0, OP_ADD = 1, OP_DEL = 2, OP_SETO = 3, OP_CLRO = 4, OP_INV = 5;

    logic                  clk, rst_n;
    logic                  init_done_o, lk_valid_i, lk_ready_o;
    logic [SW-1:0]         lk_set_i;
    logic                  rsp_valid_o;
    logic [WAYS-1:0]       rsp_valid_ways_o, rsp_owner_valid_o, rsp_dirty_o;
    logic [WAYS*CORES-1:0] rsp_sharers_o;
    logic [WAYS*CW-1:0]    rsp_owner_id_o;
    logic                  up_valid_i, up_ready_o;
    logic [SW-1:0]         up_set_i;
    logic [WW-1:0]         up_way_i;
    logic [2:0]            up_op_i;
    logic [CW-1:0]         up_core_i;
    logic [CORES-1:0]      up_sharers_i;
    logic                  up_owner_valid_i, up_dirty_i, up_err_o;

    cpu64_l2_directory_rmw #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
        .clk(clk), .rst_n(rst_n), .init_done_o(init_done_o),
        .lk_valid_i(lk_valid_i), .lk_ready_o(lk_ready_o), .lk_set_i(lk_set_i),
        .rsp_valid_o(rsp_valid_o), .rsp_valid_ways_o(rsp_valid_ways_o),
        .rsp_sharers_o(rsp_sharers_o), .rsp_owner_valid_o(rsp_owner_valid_o),
        .rsp_owner_id_o(rsp_owner_id_o), .rsp_dirty_o(rsp_dirty_o),
        .up_valid_i(up_valid_i), .up_ready_o(up_ready_o), .up_set_i(up_set_i),
        .up_way_i(up_way_i), .up_op_i(up_op_i), .up_core_i(up_core_i),
        .up_sharers_i(up_sharers_i), .up_owner_valid_i(up_owner_valid_i),
        .up_dirty_i(up_dirty_i), .up_err_o(up_err_o)
    );

    typedef struct packed {
        logic             valid;
        logic [CORES-1:0] sh;
        logic             ov;
        logic [CW-1:0]    oid;
        logic             dirty;
    } ent_t;

    typedef struct packed {
        logic [WAYS-1:0]       v;
        logic [WAYS*CORES-1:0] sh;
        logic [WAYS-1:0]       ov;
        logic [WAYS*CW-1:0]    oid;
        logic [WAYS-1:0]       d;
    } rsp_t;

    ent_t model [SETS][WAYS];
    rsp_t sb_q [$];
    bit   run_m;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_apply(input ent_t o, input int op, input int core,
                                        input logic [CORES-1:0] sh, input bit ov, input bit d,
                                        output ent_t n, output bit err);
        n   = o;
        err = 1'b0;
        case (op)
            OP_WRITE: begin n.valid = 1'b1; n.sh = sh; n.ov = ov; n.oid = CW'(core); n.dirty = d; end
            OP_ADD:   if (o.ov) err = 1'b1; else begin n.sh[core] = 1'b1; n.valid = 1'b1; end
            OP_DEL:   if (!o.valid) err = 1'b1;
                      else begin
                          n.sh[core] = 1'b0;
                          if (o.ov && o.oid == CW'(core)) begin n.ov = 1'b0; n.dirty = 1'b0; end
                      end
            OP_SETO:  begin n.valid = 1'b1; n.oid = CW'(core); n.ov = 1'b1; n.dirty = d; end
            OP_CLRO:  if (!o.ov) err = 1'b1;
                      else begin n.ov = 1'b0; n.dirty = 1'b0; n.sh = '0; n.sh[o.oid] = 1'b1; end
            OP_INV:   n = '0;
            default:  err = 1'b1;
        endcase
        if (err) begin
            n = o;
        end else begin
            if (n.dirty) n.ov = 1'b1;
            if (n.ov) n.sh = '0;
            if (!n.ov) n.oid = '0;
            if (!n.valid) n = '0;
        end
    endfunction

    task automatic drive_idle();
        up_valid_i = 1'b0; up_set_i = '0; up_way_i = '0; up_op_i = '0; up_core_i = '0;
        up_sharers_i = '0; up_owner_valid_i = 1'b0; up_dirty_i = 1'b0;
        lk_valid_i = 1'b0; lk_set_i = '0;
    endtask

    // One clock of stimulus; model and scoreboard are updated at issue, the DUT is checked after the edge.
    task automatic issue(input bit uv, input int us, input int uw, input int uop, input int ucore,
                         input logic [CORES-1:0] ush, input bit uov, input bit ud,
                         input bit lv, input int ls);
        ent_t n;
        bit   e;
        bit   exp_err;
        rsp_t exp, got;
        up_valid_i = uv; up_set_i = SW'(us); up_way_i = WW'(uw); up_op_i = 3'(uop);
        up_core_i = CW'(ucore); up_sharers_i = ush; up_owner_valid_i = uov; up_dirty_i = ud;
        lk_valid_i = lv; lk_set_i = SW'(ls);
        exp_err = 1'b0;
        if (uv && run_m) begin
            model_apply(model[us][uw], uop, ucore, ush, uov, ud, n, e);
            exp_err = e;
            if (!e) model[us][uw] = n;
        end
        if (lv && run_m) begin
            for (int w = 0; w < WAYS; w++) begin
                exp.v[w]              = model[ls][w].valid;
                exp.sh[w*CORES +: CORES] = model[ls][w].sh;
                exp.ov[w]             = model[ls][w].ov;
                exp.oid[w*CW +: CW]   = model[ls][w].oid;
                exp.d[w]              = model[ls][w].dirty;
            end
            sb_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        drive_idle();
        checks++;
        if (up_err_o !== exp_err) begin
            errors++;
            $display("FAIL up_err: got %b expected %b (set %0d way %0d op %0d)", up_err_o, exp_err, us, uw, uop);
        end
        checks++;
        if (rsp_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid 1 expected 0");
            end else begin
                exp = sb_q.pop_front();
                got = {rsp_valid_ways_o, rsp_sharers_o, rsp_owner_valid_o, rsp_owner_id_o, rsp_dirty_o};
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rsp_data set %0d: got v=%h sh=%h ov=%h oid=%h d=%h expected v=%h sh=%h ov=%h oid=%h d=%h",
                             ls, got.v, got.sh, got.ov, got.oid, got.d, exp.v, exp.sh, exp.ov, exp.oid, exp.d);
                end
            end
        end else if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_missing: got rsp_valid %b expected 1 one cycle after lookup", rsp_valid_o);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic lookup(input int s);
        issue(1'b0, 0, 0, 0, 0, '0, 1'b0, 1'b0, 1'b1, s);
    endtask

    task automatic update(input int s, input int w, input int op, input int core,
                          input logic [CORES-1:0] sh, input bit ov, input bit d);
        issue(1'b1, s, w, op, core, sh, ov, d, 1'b0, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        run_m = 1'b0;
        sb_q.delete();
        foreach (model[s, w]) model[s][w] = '0;
        @(posedge clk);
        #1;
        checks++;
        if ({init_done_o, lk_ready_o, up_ready_o, rsp_valid_o, up_err_o} !== 5'b0 ||
            rsp_valid_ways_o !== '0 || rsp_sharers_o !== '0 || rsp_owner_valid_o !== '0 ||
            rsp_owner_id_o !== '0 || rsp_dirty_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b rsp_v=%b err=%b ways=%h expected all 0",
                     init_done_o, rsp_valid_o, up_err_o, rsp_valid_ways_o);
        end
        rst_n = 1'b1;
    endtask

    // Counts cycles from reset release to init_done_o; optionally pokes requests mid-sweep.
    task automatic wait_init(input bit poke);
        int cyc;
        bit done  = 1'b0;
        bit quiet = 1'b1;
        for (cyc = 1; cyc <= SETS + 8; cyc++) begin
            if (poke && cyc == 3) begin
                up_valid_i = 1'b1; up_op_i = 3'(OP_WRITE); up_set_i = '0; up_way_i = '0;
                up_sharers_i = '1; lk_valid_i = 1'b1; lk_set_i = '0;
                if (lk_ready_o !== 1'b0 || up_ready_o !== 1'b0) quiet = 1'b0;
            end
            @(posedge clk);
            #1;
            drive_idle();
            if (init_done_o === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (rsp_valid_o !== 1'b0 || up_err_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!done || cyc != SETS) begin
            errors++;
            $display("FAIL init_latency: got %0d cycles (done=%b) expected %0d", cyc, done, SETS);
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL init_quiet: got activity or ready during sweep expected none");
        end
        checks++;
        if (lk_ready_o !== 1'b1 || up_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_init: got lk %b up %b expected 1 1", lk_ready_o, up_ready_o);
        end
        run_m = done;
    endtask

    task automatic test_reset();
        apply_reset();
        wait_init(1'b1);
    endtask

    task automatic test_init_zero();
        lookup(0);
        lookup(128);
        lookup(255);
        checks++;
        if (rsp_valid_ways_o !== '0 || rsp_sharers_o !== '0 || rsp_owner_valid_o !== '0) begin
            errors++;
            $display("FAIL init_zero: got ways=%h sh=%h expected 0", rsp_valid_ways_o, rsp_sharers_o);
        end
    endtask

    task automatic test_write();
        update(10, 5, OP_WRITE, 0, 4'b1010, 1'b0, 1'b0);
        lookup(10);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_valid_ways_o[5] !== 1'b1 || rsp_sharers_o[5*CORES +: CORES] !== 4'b1010) begin
            errors++;
            $display("FAIL write_basic: got v=%b sh=%b expected 1 1010", rsp_valid_ways_o[5], rsp_sharers_o[5*CORES +: CORES]);
        end
        update(10, 5, OP_WRITE, 1, 4'b1111, 1'b1, 1'b0);
        lookup(10);
        checks++;
        if (rsp_sharers_o[5*CORES +: CORES] !== 4'b0000 || rsp_owner_valid_o[5] !== 1'b1) begin
            errors++;
            $display("FAIL write_owner_clears_sharers: got sh=%b ov=%b expected 0000 1", rsp_sharers_o[5*CORES +: CORES], rsp_owner_valid_o[5]);
        end
        update(10, 7, OP_WRITE, 2, 4'b0001, 1'b0, 1'b1);
        lookup(10);
        checks++;
        if (rsp_owner_valid_o[7] !== 1'b1 || rsp_dirty_o[7] !== 1'b1 || rsp_owner_id_o[7*CW +: CW] !== 2'd2) begin
            errors++;
            $display("FAIL write_dirty_forces_owner: got ov=%b d=%b id=%0d expected 1 1 2", rsp_owner_valid_o[7], rsp_dirty_o[7], rsp_owner_id_o[7*CW +: CW]);
        end
    endtask

    task automatic test_sharers();
        update(20, 2, OP_ADD, 1, '0, 1'b0, 1'b0);
        update(20, 2, OP_ADD, 3, '0, 1'b0, 1'b0);
        lookup(20);
        checks++;
        if (rsp_sharers_o[2*CORES +: CORES] !== 4'b1010 || rsp_valid_ways_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL add_sharer: got sh=%b expected 1010", rsp_sharers_o[2*CORES +: CORES]);
        end
        update(20, 2, OP_SETO, 2, '0, 1'b0, 1'b1);
        lookup(20);
        checks++;
        if (rsp_sharers_o[2*CORES +: CORES] !== 4'b0000 || rsp_owner_id_o[2*CW +: CW] !== 2'd2 || rsp_dirty_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL set_owner: got sh=%b id=%0d d=%b expected 0000 2 1", rsp_sharers_o[2*CORES +: CORES], rsp_owner_id_o[2*CW +: CW], rsp_dirty_o[2]);
        end
        update(20, 2, OP_ADD, 0, '0, 1'b0, 1'b0);
        checks++;
        if (up_err_o !== 1'b1) begin
            errors++;
            $display("FAIL add_on_owned_err: got %b expected 1", up_err_o);
        end
        lookup(20);
    endtask

    task automatic test_owner_clear();
        update(20, 2, OP_CLRO, 0, '0, 1'b0, 1'b0);
        lookup(20);
        checks++;
        if (rsp_sharers_o[2*CORES +: CORES] !== 4'b0100 || rsp_owner_valid_o[2] !== 1'b0 || rsp_dirty_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL clr_owner: got sh=%b ov=%b d=%b expected 0100 0 0", rsp_sharers_o[2*CORES +: CORES], rsp_owner_valid_o[2], rsp_dirty_o[2]);
        end
        update(20, 2, OP_DEL, 2, '0, 1'b0, 1'b0);
        lookup(20);
        checks++;
        if (rsp_valid_ways_o[2] !== 1'b1 || rsp_sharers_o[2*CORES +: CORES] !== 4'b0000) begin
            errors++;
            $display("FAIL del_sharer_keeps_valid: got v=%b sh=%b expected 1 0000", rsp_valid_ways_o[2], rsp_sharers_o[2*CORES +: CORES]);
        end
        update(20, 2, OP_INV, 0, '0, 1'b0, 1'b0);
        update(20, 2, OP_DEL, 2, '0, 1'b0, 1'b0);
        checks++;
        if (up_err_o !== 1'b1) begin
            errors++;
            $display("FAIL del_on_invalid_err: got %b expected 1", up_err_o);
        end
        lookup(20);
    endtask

    task automatic test_forwarding();
        issue(1'b1, 30, 0, OP_SETO, 3, '0, 1'b0, 1'b0, 1'b1, 30);
        checks++;
        if (rsp_owner_valid_o[0] !== 1'b1 || rsp_owner_id_o[0 +: CW] !== 2'd3) begin
            errors++;
            $display("FAIL forward: got ov=%b id=%0d expected 1 3", rsp_owner_valid_o[0], rsp_owner_id_o[0 +: CW]);
        end
        issue(1'b1, 30, 0, 6, 1, 4'b1111, 1'b0, 1'b0, 1'b1, 30);
        checks++;
        if (up_err_o !== 1'b1 || rsp_owner_id_o[0 +: CW] !== 2'd3) begin
            errors++;
            $display("FAIL bad_opcode: got err=%b id=%0d expected 1 3", up_err_o, rsp_owner_id_o[0 +: CW]);
        end
    endtask

    task automatic test_back_to_back();
        lookup(10);
        lookup(20);
        lookup(30);
        lookup(0);
        lookup(10);
    endtask

    task automatic test_random();
        int sets[4] = '{10, 20, 30, 40};
        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, 99) < 70, sets[$urandom_range(0, 3)], $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, CORES - 1), CORES'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) == 0),
                  $urandom_range(0, 99) < 70, sets[$urandom_range(0, 3)]);
        end
    endtask

    task automatic test_mid_sweep_reset();
        apply_reset();
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (init_done_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_not_done: got %b expected 0", init_done_o);
        end
        apply_reset();
        wait_init(1'b0);
    endtask

    task automatic test_run_reset();
        update(50, 9, OP_SETO, 1, '0, 1'b0, 1'b1);
        apply_reset();
        wait_init(1'b0);
        lookup(10);
        lookup(20);
        lookup(50);
        checks++;
        if (rsp_valid_ways_o !== '0 || rsp_owner_valid_o !== '0 || rsp_dirty_o !== '0) begin
            errors++;
            $display("FAIL run_reset_clears: got ways=%h ov=%h expected 0", rsp_valid_ways_o, rsp_owner_valid_o);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run_m = 1'b0;
        drive_idle();
        test_reset();
        test_init_zero();
        test_write();
        test_sharers();
        test_owner_clear();
        test_forwarding();
        test_back_to_back();
        test_random();
        test_mid_sweep_reset();
        test_run_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
